// File: rtl/led_sequencer_pkg.sv
// led_pkg: shared definitions for the LED playback engine.
//   - colour codes as used on push_color / cpu_color
//   - playback FSM state encoding
//   - MMIO store addresses decoded by the wrapper into the strobes
//   - color_onehot(): colour code -> LED vector {yellow, green, blue, red}
package led_pkg;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_BLUE   = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam int unsigned ADDR_FLASH = 6;  // direct LED write
    localparam int unsigned ADDR_PUSH  = 8;  // append colour
    localparam int unsigned ADDR_CTRL  = 9;  // bit0 start, bit1 clear

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [3:0] color_onehot(input logic [1:0] color);
        logic [3:0] v;
        v        = '0;
        v[color] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: command strobes and status between the MMIO decode
// (master) and the playback engine (slave).
//   push/push_color      append a colour to the sequence
//   start / clear        begin playback / empty sequence and abort
//   cpu_flash/color/on   direct write to one LED of the manual register
//   busy, done, full, count  engine status
interface led_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [1:0]    push_color;
    logic          start;
    logic          clear;
    logic          cpu_flash;
    logic [1:0]    cpu_color;
    logic          cpu_on;
    logic          busy;
    logic          done;
    logic          full;
    logic [CW-1:0] count;

    modport master (
        output push, push_color, start, clear, cpu_flash, cpu_color, cpu_on,
        input  busy, done, full, count
    );

    modport slave (
        input  push, push_color, start, clear, cpu_flash, cpu_color, cpu_on,
        output busy, done, full, count
    );

endinterface

// File: rtl/led_sequencer_timer.sv
// seq_timer: loadable down-counter that stops at zero.
//   clock, reset  system clock, synchronous active-high reset (value 0)
//   load          load_value is taken on this cycle's edge
//   load_value    reload value
//   zero          high while the count is zero
module seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_value;
        end else if (value_q != '0) begin
            value_q <= value_q - WIDTH'(1);
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: buffers a colour sequence and plays it back on four LEDs
// with fixed on/gap timing; arbitrates the LEDs with direct CPU writes.
//   clock, reset            system clock, synchronous active-high reset
//   bus (slave)             command strobes and status, see led_sequencer_if
//   red/blue/green/yellow_led  registered LED drives
module led_sequencer
    import led_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000
) (
    input  logic           clock,
    input  logic           reset,
    led_sequencer_if.slave bus,
    output logic           red_led,
    output logic           blue_led,
    output logic           green_led,
    output logic           yellow_led
);

    localparam int unsigned IW         = $clog2(DEPTH);
    localparam int unsigned CW         = IW + 1;
    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    manual_q, manual_d;
    logic [3:0]    leds_q, leds_d;
    logic          done_q, done_d;
    logic [1:0]    mem [DEPTH];
    logic          mem_we;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_zero;
    logic          full_w;

    assign full_w = (count_q == CW'(DEPTH));

    seq_timer #(.WIDTH(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    // LED value is computed for the next state so every LED output is a flop.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        manual_d  = manual_q;
        leds_d    = leds_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = ON_LOAD;

        if (bus.clear) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            count_d  = '0;
            manual_d = '0;
            leds_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (count_q != '0)) begin
                        state_d   = ST_ON;
                        idx_d     = '0;
                        tmr_load  = 1'b1;
                        tmr_value = ON_LOAD;
                        manual_d  = '0;
                        leds_d    = color_onehot(mem[idx_d]);
                    end else begin
                        if (bus.start) begin
                            done_d = 1'b1;
                        end else if (bus.push && !full_w) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                        if (bus.cpu_flash) begin
                            manual_d[bus.cpu_color] = bus.cpu_on;
                        end
                        leds_d = manual_d;
                    end
                end
                ST_ON: begin
                    if (tmr_zero) begin
                        state_d   = ST_GAP;
                        tmr_load  = 1'b1;
                        tmr_value = OFF_LOAD;
                        leds_d    = '0;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        if ({1'b0, idx_q} == (count_q - CW'(1))) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            leds_d  = manual_q;
                        end else begin
                            state_d   = ST_ON;
                            idx_d     = idx_q + IW'(1);
                            tmr_load  = 1'b1;
                            tmr_value = ON_LOAD;
                            leds_d    = color_onehot(mem[idx_d]);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    leds_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            manual_q <= '0;
            leds_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            manual_q <= manual_d;
            leds_q   <= leds_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[count_q[IW-1:0]] <= bus.push_color;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.full  = full_w;
    assign bus.count = count_q;

    assign red_led    = leds_q[0];
    assign blue_led   = leds_q[1];
    assign green_led  = leds_q[2];
    assign yellow_led = leds_q[3];

endmodule
